debounce_sync: RTL and testbench

//   Conditions one raw asynchronous level input, such as a push-button or switch,

---
 rtl/debounce_sync.sv | 189 ++++++++++++++++++
 tb/tb_debounce_sync.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
//   Conditions one raw asynchronous level input (push-button, switch) into a
//   clean registered level with a complementary copy, plus one-clock rise and
//   fall strobes on the edge where the clean level changes.
//
//   Flow: synchroniser -> two-state stability FSM with counter -> registered
//   outputs. The clean level only follows the synchronised input once the
//   two have disagreed for STABLE_CNT consecutive clocks. Any agreement in
//   between is treated as a glitch and restarts the count from zero.
//
// Parameters
//   STABLE_CNT : consecutive mismatching clocks before dout follows (>= 2)
//   CNT_W      : counter width, 2**CNT_W >= STABLE_CNT
//
// Configuration macro
//   DEBOUNCE_SYNC2_EN : defined   -> two-flop synchroniser (N=2)
//                       undefined -> single-flop synchroniser (N=1)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   din       in   raw input, asynchronous to clk, may bounce
//   dout      out  debounced level, registered
//   dout_b    out  always ~dout, registered
//   rise      out  one-clock pulse on the edge dout goes 0->1
//   fall      out  one-clock pulse on the edge dout goes 1->0
//   dbg_state out  current FSM state (0 = STABLE, 1 = CHANGING)
//   dbg_cnt   out  current stability count
//
// Handshake: none. din is a free-running level; outputs are plain levels
// and single-cycle strobes with no valid/ready qualification.
// ---------------------------------------------------------------------------
module debounce_sync #(
  parameter int STABLE_CNT = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic             dout,
  output logic             dout_b,
  output logic             rise,
  output logic             fall,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } state_t;

  // Count value on which the STABLE_CNT-th consecutive mismatch lands.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             w_s;
  logic             w_mismatch;
  logic             w_cnt_last;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dout;
  logic             r_dout_b;
  logic             r_rise;
  logic             r_fall;
  logic             w_dout_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
`ifdef DEBOUNCE_SYNC2_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  logic r_sync1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
    end else begin
      r_sync1 <= din;
    end
  end

  assign w_s = r_sync1;
`endif

  assign w_mismatch = w_s ^ r_dout;
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  // -------------------------------------------------------------------------
  // State register (also holds the counter and the registered outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_STABLE;
      r_cnt    <= '0;
      r_dout   <= 1'b0;
      r_dout_b <= 1'b1;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dout   <= w_dout_nxt;
      r_dout_b <= ~w_dout_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STABLE: begin
        if (w_mismatch) begin
          w_state_nxt = ST_CHANGING;
        end
      end
      ST_CHANGING: begin
        // Back to STABLE either on a glitch or once the output has followed.
        if (!w_mismatch || w_cnt_last) begin
          w_state_nxt = ST_STABLE;
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic: next counter, level and strobe values
  // -------------------------------------------------------------------------
  always_comb begin
    w_cnt_nxt  = '0;
    w_dout_nxt = r_dout;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_mismatch) begin
          w_cnt_nxt = CNT_W'(1);
        end
      end
      ST_CHANGING: begin
        if (w_mismatch) begin
          if (w_cnt_last) begin
            // Strobes derive from the new level so they can never both fire.
            w_dout_nxt = w_s;
            w_rise_nxt = w_s;
            w_fall_nxt = ~w_s;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign dout      = r_dout;
  assign dout_b    = r_dout_b;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync
//   Self-checking bench for debounce_sync with STABLE_CNT=4. The reference
//   model delays din through a queue of N samples and tracks the length of
//   the current run of disagreement between the delayed input and the
//   modelled clean level; the level flips once that run reaches STABLE_CNT.
// ---------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int SC = 4;
  localparam int CW = 3;
`ifdef DEBOUNCE_SYNC2_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          din;
  logic          dout;
  logic          dout_b;
  logic          rise;
  logic          fall;
  logic          dbg_state;
  logic [CW-1:0] dbg_cnt;

  always #5 clk = ~clk;

  debounce_sync #(
    .STABLE_CNT (SC),
    .CNT_W      (CW)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .dout      (dout),
    .dout_b    (dout_b),
    .rise      (rise),
    .fall      (fall),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW+3:0] exp_q[$];   // {dout, dout_b, rise, fall, cnt}
  logic          dly_q[$];   // din samples on their way through the synchroniser
  logic          m_dout;
  int            m_run;
  int            edge_no;
  int            rise_cnt;
  int            fall_cnt;
  int            last_rise_edge;
  int            last_fall_edge;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    dly_q.delete();
    for (int i = 0; i < N; i++) dly_q.push_back(1'b0);
    exp_q.delete();
    m_dout = 1'b0;
    m_run  = 0;
  endtask

  task automatic model_edge(input logic d);
    logic s;
    logic r;
    logic f;
    r = 1'b0;
    f = 1'b0;
    s = dly_q.pop_front();
    dly_q.push_back(d);
    if (s != m_dout) begin
      m_run++;
      if (m_run == SC) begin
        m_dout = s;
        r      = s;
        f      = ~s;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    exp_q.push_back({m_dout, ~m_dout, r, f, CW'(m_run)});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives din, waits one rising edge, checks.
  task automatic step(input logic d);
    logic [CW+3:0] e;
    din = d;
    @(posedge clk);
    model_edge(d);
    edge_no++;
    #1;
    e = exp_q.pop_front();
    check("dout",   dout,    e[CW+3]);
    check("dout_b", dout_b,  e[CW+2]);
    check("rise",   rise,    e[CW+1]);
    check("fall",   fall,    e[CW]);
    check("cnt",    dbg_cnt, e[CW-1:0]);
    if (rise) begin
      rise_cnt++;
      last_rise_edge = edge_no;
    end
    if (fall) begin
      fall_cnt++;
      last_fall_edge = edge_no;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},   dout,   1'b0);
    check({tag, "_dout_b"}, dout_b, 1'b1);
    check({tag, "_rise"},   rise,   1'b0);
    check({tag, "_fall"},   fall,   1'b0);
    check({tag, "_cnt"},    dbg_cnt, '0);
  endtask

  // Asserts reset away from the clock edge, holds it over two rising edges
  // and releases it on a falling edge with din held at d throughout.
  task automatic do_reset(input logic d);
    reset = 1'b1;
    din   = d;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    reset          = 1'b0;
    edge_no        = 0;
    rise_cnt       = 0;
    fall_cnt       = 0;
    last_rise_edge = -1;
    last_fall_edge = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic bounce[6];
    logic b;
    int   len;
    int   base;

    reset = 1'b0;
    din   = 1'b0;
    #1;

    // Reset with din low; outputs stay idle afterwards.
    do_reset(1'b0);
    repeat (3) step(1'b0);

    // din high before edge 1 and held: single rise at edge N+SC.
    do_reset(1'b0);
    repeat (N + SC + 3) step(1'b1);
    check("t2_rise_edge", last_rise_edge, N + SC);
    check("t2_rise_cnt",  rise_cnt,       1);

    // Three-clock glitch is rejected and the count returns to zero.
    do_reset(1'b0);
    repeat (3) step(1'b1);
    repeat (N + SC + 2) step(1'b0);
    check("t3_rise_cnt", rise_cnt, 0);
    check("t3_cnt_idle", dbg_cnt,  '0);
    check("t3_dout",     dout,     1'b0);

    // Bounce 1,0,1,1,0,1 then held high: one rise, timed from the last 0->1.
    do_reset(1'b0);
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (bounce[i]) step(bounce[i]);
    repeat (N + SC + 3) step(1'b1);
    check("t4_rise_cnt",  rise_cnt,       1);
    check("t4_rise_edge", last_rise_edge, 5 + N + SC);

    // From dout=1, din falls and holds: single fall at N+SC edges later.
    base = edge_no;
    repeat (N + SC + 3) step(1'b0);
    check("t5_fall_cnt",  fall_cnt,       1);
    check("t5_fall_edge", last_fall_edge, base + N + SC);
    check("t5_dout_b",    dout_b,         1'b1);

    // Reset mid-count with din held high: count discarded, full latency again.
    do_reset(1'b0);
    repeat (N + 2) step(1'b1);
    check("t6_cnt_mid", dbg_cnt, CW'(2));
    do_reset(1'b1);
    repeat (N + SC + 3) step(1'b1);
    check("t6_rise_edge", last_rise_edge, N + SC);
    check("t6_rise_cnt",  rise_cnt,       1);

    // Randomized runs of varying length, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, SC + 3);
      if ($urandom_range(0, 40) == 0) do_reset(b);
      repeat (len) step(b);
    end
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
